switch_led_ctrl: RTL
====================

SWITCH_LED_CTRL -- requirements
Module: switch_led_ctrl

Interface
REQ-001 SHALL have parameter N_SW, default 8: switch count, legal range 4..32.
REQ-002 SHALL have parameter N_LED, default 8: LED count, legal range 1..32.
REQ-003 SHALL have parameter DEB_CYCLES, default 16: stable cycles needed to accept a switch change, minimum 1.
REQ-004 SHALL have parameter TICK_DIV, default 4: clock cycles per animation tick, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port switch, input, N_SW bits: raw asynchronous switch levels.
REQ-008 SHALL have port led, output, N_LED bits: registered LED drive.

Function
REQ-009 SHALL pass each switch bit through a two-flop synchronizer (sync).
REQ-010 SHALL update a debounced bit db[i] per switch: the counter clears while sync[i]==db[i], increments while they differ, and db[i] flips when the count reaches DEB_CYCLES-1; latency from raw edge to db change is 2+DEB_CYCLES cycles.
REQ-011 SHALL ignore a glitch shorter than DEB_CYCLES synced cycles; db stays unchanged.
REQ-012 SHALL pulse tick for one cycle every TICK_DIV cycles; tick is constant 1 when TICK_DIV==1.
REQ-013 SHALL select the mode from db[1:0]: 0 STATIC, 1 SHIFT, 2 BOUNCE, 3 COUNT.
REQ-014 STATIC: led = db[N_SW-1:2], zero-extended or truncated to N_LED, registered with 1 cycle latency.
REQ-015 SHIFT: a one-hot bit rotates left each tick; bit N_LED-1 wraps to bit 0.
REQ-016 BOUNCE: a one-hot bit moves in direction dir each tick; dir reverses when the bit is at bit N_LED-1 (going up) or bit 0 (going down), so no end position repeats; with N_LED==1, led stays 1.
REQ-017 COUNT: led increments by 1 each tick, modulo 2^N_LED; all-ones wraps to 0.
REQ-018 SHALL reload on the cycle after any db[1:0] change: the pattern becomes led=1 (SHIFT/BOUNCE) or 0 (COUNT), dir=up, and the tick counter =0; a tick in that same cycle is discarded.

Reset
REQ-019 SHALL on rst_n low, asynchronously clear sync, db, the debounce counters, the tick counter, dir (up) and led to 0.
REQ-020 SHALL on reset release start in STATIC with led=0; a switch already high appears after 2+DEB_CYCLES cycles.
REQ-021 SHALL apply reset asserted mid-animation immediately, with no partial update.

Configuration
REQ-022 SHALL, with SWLED_PAUSE_EN defined, treat db[2] high as pause: ticks are suppressed in SHIFT/BOUNCE/COUNT, led holds its value, and the tick counter holds; db[2] still contributes to the STATIC pattern.
REQ-023 SHALL, without SWLED_PAUSE_EN, use db[2] only as STATIC pattern data, with animation never paused.

Structure
REQ-024 SHALL place the mode enum (STATIC, SHIFT, BOUNCE, COUNT) and the reload constants in package switch_led_pkg.
REQ-025 SHALL implement one sub-module, sw_debounce (parameter DEB_CYCLES, synchronizer plus counter for 1 bit), instantiated N_SW times by generate.

Verification
Bench parameters: N_SW=8, N_LED=8, DEB_CYCLES=4, TICK_DIV=2, unless a line says otherwise.
REQ-026 SHALL cover debounce: switch[5] pulses high for 2 cycles, then high steady -> db[5] rises exactly 6 cycles after the steady edge; led in STATIC = 0x08.
REQ-027 SHALL cover SHIFT wrap: mode=1 -> led 0x01, 0x02 ... 0x80, 0x01, one step per 2 cycles.
REQ-028 SHALL cover BOUNCE: mode=2 -> led 0x01..0x80, then 0x40..0x01, then 0x02; with N_LED=1 led stays 0x1.
REQ-029 SHALL cover COUNT wrap and reload: COUNT run to 0xFF -> next tick 0x00; switching to SHIFT mid-count -> led=0x01 on the cycle after db changes.
REQ-030 SHALL cover async reset mid-BOUNCE: rst_n low between edges -> led=0 immediately; after release led=0 until the mode is re-debounced.
REQ-031 SHALL cover pause with SWLED_PAUSE_EN: db[2]=1 in COUNT at 0x05 -> led holds 0x05 for 20 cycles; release -> 0x06 after 2 cycles.

Source files
------------

// File: rtl/switch_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_led_pkg
// Description : Shared types and constants for the switch/LED controller:
//               the animation mode encoding, bounce direction values, the
//               pattern reload constants and a counter-width helper.
// Ports       : none (package)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
package switch_led_pkg;

  // Mode is taken straight from the two lowest debounced switches.
  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic c_DIR_UP   = 1'b0;
  localparam logic c_DIR_DOWN = 1'b1;

  // Pattern loaded on a mode change; cast down to the LED width at the use site.
  localparam logic [31:0] c_RELOAD_ONEHOT = 32'd1;
  localparam logic [31:0] c_RELOAD_COUNT  = 32'd0;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : switch_led_pkg
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : One-bit switch conditioner: two-flop synchronizer followed by
//               a stability counter. The debounced output flips only after the
//               synchronized input has disagreed with it for DEB_CYCLES
//               consecutive cycles; any agreement clears the count.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               raw_i  - raw asynchronous switch level
//               db_o   - debounced level
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce
  import switch_led_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic db_o
);

  localparam int unsigned     c_CW       = cnt_width(DEB_CYCLES);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEB_CYCLES - 1);

  logic            meta_q;
  logic            sync_q;
  logic            db_q;
  logic [c_CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      if (sync_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == c_CNT_LAST) begin
        // The disagreeing cycle that reaches the last count is the
        // DEB_CYCLES-th one, so the change is accepted here.
        db_q  <= ~db_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + c_CW'(1);
      end
    end
  end

  assign db_o = db_q;

endmodule : sw_debounce
`default_nettype wire

// File: rtl/switch_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : switch_led_ctrl
// Description : Debounces N_SW switches and drives N_LED LEDs. db[1:0] select
//               STATIC (db[N_SW-1:2] shown directly), SHIFT (rotating one-hot),
//               BOUNCE (one-hot ping-pong) or COUNT (binary up-counter).
//               Animations advance once per TICK_DIV clocks; any change of
//               db[1:0] reloads the pattern and restarts the tick phase.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               switch - [N_SW-1:0] raw switch levels
//               led    - [N_LED-1:0] registered LED drive
// Config      : SWLED_PAUSE_EN - when defined, db[2] high freezes the
//               animation (led and tick phase hold) in SHIFT/BOUNCE/COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int unsigned N_SW       = 8,
  parameter int unsigned N_LED      = 8,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned TICK_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  switch,
  output logic [N_LED-1:0] led
);

  localparam int unsigned     c_TW        = cnt_width(TICK_DIV);
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);

  logic [N_SW-1:0] db;

  for (genvar gi = 0; gi < N_SW; gi++) begin : g_deb
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw_i(switch[gi]),
      .db_o (db[gi])
    );
  end

  // STATIC pattern: db[N_SW-1:2] fitted to the LED width.
  logic [N_LED-1:0] static_pat;

  if (N_LED <= N_SW - 2) begin : g_static_trunc
    assign static_pat = db[N_LED+1:2];
  end else begin : g_static_ext
    assign static_pat = {{(N_LED - N_SW + 2){1'b0}}, db[N_SW-1:2]};
  end

  logic [1:0]       mode_prev_q;
  logic [c_TW-1:0]  tcnt_q, tcnt_d;
  logic             dir_q, dir_d;
  logic [N_LED-1:0] led_q, led_d;

  mode_e mode;
  logic  reload;
  logic  pause;
  logic  tick;

  assign mode   = mode_e'(db[1:0]);
  // Comparing against last cycle's mode bits catches every change exactly once.
  assign reload = (db[1:0] != mode_prev_q);

`ifdef SWLED_PAUSE_EN
  assign pause = db[2] && (mode != MODE_STATIC);
`else
  assign pause = 1'b0;
`endif

  // With TICK_DIV==1 the counter is pinned at 0 == c_TICK_LAST, so tick is constant.
  assign tick = (tcnt_q == c_TICK_LAST) && !pause;

  always_comb begin
    tcnt_d = tcnt_q;
    dir_d  = dir_q;
    led_d  = led_q;
    if (reload) begin
      // Restart phase and pattern; a tick coinciding with the change is dropped.
      tcnt_d = '0;
      dir_d  = c_DIR_UP;
      unique case (mode)
        MODE_STATIC: led_d = static_pat;
        MODE_COUNT:  led_d = N_LED'(c_RELOAD_COUNT);
        default:     led_d = N_LED'(c_RELOAD_ONEHOT);
      endcase
    end else begin
      if (!pause) begin
        tcnt_d = (tcnt_q == c_TICK_LAST) ? '0 : tcnt_q + c_TW'(1);
      end
      unique case (mode)
        MODE_STATIC: led_d = static_pat;
        MODE_SHIFT: begin
          if (tick) begin
            led_d = (led_q << 1) | (led_q >> (N_LED - 1));
          end
        end
        MODE_BOUNCE: begin
          // A single LED has nowhere to move, so it just stays lit.
          if (tick && (N_LED > 1)) begin
            if (dir_q == c_DIR_UP) begin
              if (led_q[N_LED-1]) begin
                led_d = led_q >> 1;
                dir_d = c_DIR_DOWN;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d = led_q << 1;
                dir_d = c_DIR_UP;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
        end
        MODE_COUNT: begin
          if (tick) begin
            led_d = led_q + N_LED'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_prev_q <= 2'b00;
      tcnt_q      <= '0;
      dir_q       <= c_DIR_UP;
      led_q       <= '0;
    end else begin
      mode_prev_q <= db[1:0];
      tcnt_q      <= tcnt_d;
      dir_q       <= dir_d;
      led_q       <= led_d;
    end
  end

  assign led = led_q;

endmodule : switch_led_ctrl
`default_nettype wire
